// File: rtl/multi_region_bit_reader_if.sv
// multi_region_bit_reader_if
//   Pixel output stream of multi_region_bit_reader (ready/valid).
//   bit_pixels    : one 8-bit lane per pixel of a RAM word, lane i = {bit i, 7'b0}
//   pixels_sof    : first word of a frame
//   pixels_region : region the head word came from
//   pixels_valid  : head word present
//   pixels_ready  : consumer takes the head word on valid & ready
interface multi_region_bit_reader_if #(
  parameter int NUM_REGIONS   = 3,
  parameter int BITS_PER_READ = 8
);
  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic [8*BITS_PER_READ-1:0] bit_pixels;
  logic                       pixels_sof;
  logic [RW-1:0]              pixels_region;
  logic                       pixels_valid;
  logic                       pixels_ready;

  modport master (output bit_pixels, pixels_sof, pixels_region, pixels_valid,
                  input  pixels_ready);
  modport slave  (input  bit_pixels, pixels_sof, pixels_region, pixels_valid,
                  output pixels_ready);
endinterface

// File: rtl/multi_region_bit_reader.sv
// multi_region_bit_reader
//   Streams a binarised frame out of NUM_REGIONS dual-buffered region RAMs
//   (regions read 0..NUM_REGIONS-1) into an output FIFO, expanding each RAM
//   bit into an 8-bit pixel lane. Any RAM read latency >= 1 is tolerated;
//   issue is throttled so in-flight reads always have FIFO space.
// Ports
//   pclk, pclk_reset : clock, synchronous active-high reset
//   image_number     : frame request, a change vs. the last accepted value starts a frame
//   rd_address       : shared address to all region RAMs
//   rd_data          : region r on [r*BITS_PER_READ +: BITS_PER_READ], RD_LATENCY after address
//   frame_done       : one-cycle pulse when the last address of a frame is issued
//   overrun          : sticky, image_number changed while reading
//   pix              : pixel stream (multi_region_bit_reader_if.master)
// Build option
//   BPR_OVERRUN_DETECT_EN : enables the overrun flag; otherwise overrun is 0.
module multi_region_bit_reader #(
  parameter int NUM_REGIONS   = 3,
  parameter int EDGE_WIDTH    = 240,
  parameter int CENTER_WIDTH  = 304,
  parameter int HEIGHT        = 480,
  parameter int BITS_PER_READ = 8,
  parameter int ADDR_W        = 16,
  parameter int RD_LATENCY    = 1,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                                 pclk,
  input  logic                                 pclk_reset,
  input  logic [3:0]                           image_number,
  output logic [ADDR_W-1:0]                    rd_address,
  input  logic [NUM_REGIONS*BITS_PER_READ-1:0] rd_data,
  output logic                                 frame_done,
  output logic                                 overrun,
  multi_region_bit_reader_if.master            pix
);
  localparam int RW  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [ADDR_W-1:0] READS_EDGE   = ADDR_W'(EDGE_WIDTH*HEIGHT/BITS_PER_READ);
  localparam logic [ADDR_W-1:0] READS_CENTER = ADDR_W'(CENTER_WIDTH*HEIGHT/BITS_PER_READ);
  localparam logic [RW-1:0]     LAST_REGION  = RW'(NUM_REGIONS-1);
  localparam logic [CW1-1:0]    DEPTH_C      = CW1'(FIFO_DEPTH);

  typedef enum logic {IDLE, READ} state_t;

  typedef struct packed {
    logic [BITS_PER_READ-1:0] data;
    logic                     sof;
    logic [RW-1:0]            region;
  } fifo_word_t;

  state_t            state_q, state_n;
  logic [RW-1:0]     region_q, region_n, region_inc;
  logic              buf_q, buf_n;
  logic [3:0]        img_q, img_n;
  logic              sof_pend_q, sof_pend_n;
  logic [ADDR_W-1:0] addr_n, cur_reads, nxt_reads, last_addr;
  logic              done_n, issue, room;

  logic [CW-1:0]     usedw_q, inflight_q;
  logic [CW1-1:0]    occ;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              wr_en, rd_en, valid;
  fifo_word_t        mem [FIFO_DEPTH];
  fifo_word_t        wr_word, head;
  logic [8*BITS_PER_READ-1:0] lanes;

  // issue tags, one stage per cycle of RAM latency; exit at RD_LATENCY-1
  logic [RD_LATENCY-1:0]         vld_pipe, sof_pipe;
  logic [RD_LATENCY-1:0][RW-1:0] rgn_pipe;

  // region geometry: edge regions use EDGE_WIDTH, the rest CENTER_WIDTH
  assign region_inc = region_q + 1'b1;
  assign cur_reads  = (region_q == '0 || region_q == LAST_REGION) ? READS_EDGE : READS_CENTER;
  assign nxt_reads  = (region_inc == LAST_REGION) ? READS_EDGE : READS_CENTER;
  assign last_addr  = (buf_q ? cur_reads : '0) + cur_reads - 1'b1;

  // in-flight reads reserve their FIFO slot at issue time
  assign occ  = {1'b0, inflight_q} + {1'b0, usedw_q};
  assign room = (occ < DEPTH_C);

  always_ff @(posedge pclk) begin
    if (pclk_reset) state_q <= IDLE;
    else            state_q <= state_n;
  end

  always_comb begin
    state_n    = state_q;
    region_n   = region_q;
    buf_n      = buf_q;
    addr_n     = rd_address;
    img_n      = img_q;
    sof_pend_n = sof_pend_q;
    done_n     = 1'b0;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        // the frame_done cycle is skipped so a request lands one cycle later
        if (!frame_done && image_number != img_q) begin
          img_n      = image_number;
          region_n   = '0;
          addr_n     = buf_q ? READS_EDGE : '0;
          sof_pend_n = 1'b1;
          state_n    = READ;
        end
      end
      READ: begin
        issue = room;
        if (issue) begin
          sof_pend_n = 1'b0;
          if (rd_address == last_addr) begin
            if (region_q != LAST_REGION) begin
              region_n = region_inc;
              addr_n   = buf_q ? nxt_reads : '0;
            end else begin
              done_n  = 1'b1;
              buf_n   = ~buf_q;
              state_n = IDLE;
            end
          end else begin
            addr_n = rd_address + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (pclk_reset) begin
      region_q   <= '0;
      buf_q      <= 1'b0;
      img_q      <= '0;
      sof_pend_q <= 1'b0;
      rd_address <= '0;
      frame_done <= 1'b0;
    end else begin
      region_q   <= region_n;
      buf_q      <= buf_n;
      img_q      <= img_n;
      sof_pend_q <= sof_pend_n;
      rd_address <= addr_n;
      frame_done <= done_n;
    end
  end

`ifdef BPR_OVERRUN_DETECT_EN
  // the request itself stays pending: img_q is untouched, IDLE picks it up
  always_ff @(posedge pclk) begin
    if (pclk_reset)                                      overrun <= 1'b0;
    else if (state_q == READ && image_number != img_q)   overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (pclk_reset) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
      rgn_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      sof_pipe[0] <= issue & sof_pend_q;
      rgn_pipe[0] <= region_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sof_pipe[i] <= sof_pipe[i-1];
        rgn_pipe[i] <= rgn_pipe[i-1];
      end
    end
  end

  // FIFO: write when a tag leaves the pipe, alongside its RAM data
  assign wr_en          = vld_pipe[RD_LATENCY-1];
  assign wr_word.data   = rd_data[rgn_pipe[RD_LATENCY-1]*BITS_PER_READ +: BITS_PER_READ];
  assign wr_word.sof    = sof_pipe[RD_LATENCY-1];
  assign wr_word.region = rgn_pipe[RD_LATENCY-1];
  assign valid          = (usedw_q != '0);
  assign rd_en          = valid & pix.pixels_ready;

  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge pclk) begin
    if (pclk_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      usedw_q    <= '0;
      inflight_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   usedw_q <= usedw_q + 1'b1;
        2'b01:   usedw_q <= usedw_q - 1'b1;
        default: ;
      endcase
      case ({issue, wr_en})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: ;
      endcase
    end
  end

  // show-ahead head; outputs held at 0 while empty so nothing stale shows
  assign head = mem[rd_ptr];

  always_comb begin
    lanes = '0;
    for (int i = 0; i < BITS_PER_READ; i++) lanes[8*i+7] = head.data[i];
  end

  assign pix.pixels_valid  = valid;
  assign pix.pixels_sof    = valid & head.sof;
  assign pix.pixels_region = valid ? head.region : '0;
  assign pix.bit_pixels    = valid ? lanes : '0;
endmodule
